// File: rtl/operand_stage_pkg.sv
// rtl/operand_stage_pkg.sv - shared types and helpers for the operand stage
// Holds the ID/EX output-register layout, the x0 register index and the
// x0-compare helper used by the hazard and forwarding logic.
package operand_stage_pkg;

  // Widest PC/data width the output register can carry; the top casts its
  // parameterised ports into these fields.
  localparam int XLEN = 32;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1data;
    logic [XLEN-1:0] rs2data;
    logic            regwren;
    logic            memren;
    logic            fwd_rs1;
    logic            fwd_rs2;
  } id_ex_t;

  function automatic logic is_zero_reg(input logic [4:0] r);
    return r == ZERO_REG;
  endfunction

endpackage

// File: rtl/operand_stage_fwd_mux.sv
// rtl/operand_stage_fwd_mux.sv - per-source operand selection and EX forward flags
// Ports: rs1/rs2 + uses_rs1/uses_rs2 (decoded sources), rs1data/rs2data
// (register file), mem_* (MEM-stage result), ex_* (current output register),
// op1/op2 (captured operands), fwd_rs1/fwd_rs2 (execute substitutes its ALU result).
module operand_fwd_mux
  import operand_stage_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic              uses_rs1,
  input  logic              uses_rs2,
  input  logic [DWIDTH-1:0] rs1data,
  input  logic [DWIDTH-1:0] rs2data,
  input  logic              mem_valid,
  input  logic              mem_regwren,
  input  logic [4:0]        mem_rd,
  input  logic [DWIDTH-1:0] mem_data,
  input  logic              ex_valid,
  input  logic              ex_regwren,
  input  logic              ex_memren,
  input  logic [4:0]        ex_rd,
  output logic [DWIDTH-1:0] op1,
  output logic [DWIDTH-1:0] op2,
  output logic              fwd_rs1,
  output logic              fwd_rs2
);

  logic mem_hit1;
  logic mem_hit2;
  logic ex_alu_src;

  assign mem_hit1 = mem_valid && mem_regwren && (mem_rd == rs1);
  assign mem_hit2 = mem_valid && mem_regwren && (mem_rd == rs2);

  // x0 wins over any bypass, even a MEM result that names x0.
  assign op1 = is_zero_reg(rs1) ? '0 : (mem_hit1 ? mem_data : rs1data);
  assign op2 = is_zero_reg(rs2) ? '0 : (mem_hit2 ? mem_data : rs2data);

  // Only an ALU result can be forwarded from execute; a load in the output
  // register is handled by the load-use bubble instead.
  assign ex_alu_src = ex_valid && !ex_memren && ex_regwren && !is_zero_reg(ex_rd);

  assign fwd_rs1 = ex_alu_src && uses_rs1 && (rs1 == ex_rd);
  assign fwd_rs2 = ex_alu_src && uses_rs2 && (rs2 == ex_rd);

endmodule

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - ID/EX operand stage with load-use stall and bypassing
// Ports: clk/rst (sync, active-high); id_* (decoded instruction handshake and
// fields); rs1data_i/rs2data_i (register file); mem_* (MEM-stage result);
// flush_i (redirect); ex_* (registered output with valid/ready and forward
// flags); stall_cnt_o (saturating load-use bubble count).
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [AWIDTH-1:0] id_pc_i,
  input  logic [31:0]       id_insn_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic              id_regwren_i,
  input  logic              id_memren_i,
  input  logic [DWIDTH-1:0] rs1data_i,
  input  logic [DWIDTH-1:0] rs2data_i,
  input  logic              mem_valid_i,
  input  logic              mem_regwren_i,
  input  logic [4:0]        mem_rd_i,
  input  logic [DWIDTH-1:0] mem_data_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [AWIDTH-1:0] ex_pc_o,
  output logic [31:0]       ex_insn_o,
  output logic [DWIDTH-1:0] ex_rs1data_o,
  output logic [DWIDTH-1:0] ex_rs2data_o,
  output logic [4:0]        ex_rd_o,
  output logic              ex_regwren_o,
  output logic              ex_memren_o,
  output logic              ex_fwd_rs1_o,
  output logic              ex_fwd_rs2_o,
  output logic [31:0]       stall_cnt_o
);

  id_ex_t            ex_q;
  id_ex_t            capture;
  id_ex_t            bubble;
  logic [31:0]       stall_cnt_q;
  logic              free;
  logic              hazard;
  logic [DWIDTH-1:0] op1;
  logic [DWIDTH-1:0] op2;
  logic              fwd1;
  logic              fwd2;

  operand_fwd_mux #(.DWIDTH(DWIDTH)) u_fwd_mux (
    .rs1         (id_rs1_i),
    .rs2         (id_rs2_i),
    .uses_rs1    (id_uses_rs1_i),
    .uses_rs2    (id_uses_rs2_i),
    .rs1data     (rs1data_i),
    .rs2data     (rs2data_i),
    .mem_valid   (mem_valid_i),
    .mem_regwren (mem_regwren_i),
    .mem_rd      (mem_rd_i),
    .mem_data    (mem_data_i),
    .ex_valid    (ex_q.valid),
    .ex_regwren  (ex_q.regwren),
    .ex_memren   (ex_q.memren),
    .ex_rd       (ex_q.rd),
    .op1         (op1),
    .op2         (op2),
    .fwd_rs1     (fwd1),
    .fwd_rs2     (fwd2)
  );

  assign free = !ex_q.valid || ex_ready_i;

  assign hazard = ex_q.valid && ex_q.memren && !is_zero_reg(ex_q.rd) &&
                  ((id_uses_rs1_i && (id_rs1_i == ex_q.rd)) ||
                   (id_uses_rs2_i && (id_rs2_i == ex_q.rd)));

  // A flush always "accepts" so decode can drop its wrong-path instruction.
  assign id_ready_o = !rst && (flush_i || (free && !hazard));

  always_comb begin
    capture         = ex_q;
    capture.valid   = 1'b1;
    capture.pc      = XLEN'(id_pc_i);
    capture.insn    = id_insn_i;
    capture.rd      = id_rd_i;
    capture.rs1data = XLEN'(op1);
    capture.rs2data = XLEN'(op2);
    capture.regwren = id_regwren_i;
    capture.memren  = id_memren_i;
    capture.fwd_rs1 = fwd1;
    capture.fwd_rs2 = fwd2;
  end

  // Payload is left as-is in a bubble; only the side-effect bits are cleared.
  always_comb begin
    bubble         = ex_q;
    bubble.valid   = 1'b0;
    bubble.regwren = 1'b0;
    bubble.memren  = 1'b0;
    bubble.fwd_rs1 = 1'b0;
    bubble.fwd_rs2 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else if (flush_i) begin
      ex_q <= bubble;
    end else if (free) begin
      if (hazard) begin
        ex_q <= bubble;
        if (stall_cnt_q != 32'hFFFF_FFFF) begin
          stall_cnt_q <= stall_cnt_q + 32'd1;
        end
      end else if (id_valid_i) begin
        ex_q <= capture;
      end else begin
        ex_q <= bubble;
      end
    end
  end

  assign ex_valid_o   = ex_q.valid;
  assign ex_pc_o      = AWIDTH'(ex_q.pc);
  assign ex_insn_o    = ex_q.insn;
  assign ex_rs1data_o = DWIDTH'(ex_q.rs1data);
  assign ex_rs2data_o = DWIDTH'(ex_q.rs2data);
  assign ex_rd_o      = ex_q.rd;
  assign ex_regwren_o = ex_q.regwren;
  assign ex_memren_o  = ex_q.memren;
  assign ex_fwd_rs1_o = ex_q.fwd_rs1;
  assign ex_fwd_rs2_o = ex_q.fwd_rs2;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - directed self-checking bench for operand_stage
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_insn;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_regwren;
  logic        id_memren;
  logic [31:0] rs1data;
  logic [31:0] rs2data;
  logic        mem_valid;
  logic        mem_regwren;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_insn;
  logic [31:0] ex_rs1data;
  logic [31:0] ex_rs2data;
  logic [4:0]  ex_rd;
  logic        ex_regwren;
  logic        ex_memren;
  logic        ex_fwd_rs1;
  logic        ex_fwd_rs2;
  logic [31:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid_i    (id_valid),
    .id_ready_o    (id_ready),
    .id_pc_i       (id_pc),
    .id_insn_i     (id_insn),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_rd_i       (id_rd),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .id_regwren_i  (id_regwren),
    .id_memren_i   (id_memren),
    .rs1data_i     (rs1data),
    .rs2data_i     (rs2data),
    .mem_valid_i   (mem_valid),
    .mem_regwren_i (mem_regwren),
    .mem_rd_i      (mem_rd),
    .mem_data_i    (mem_data),
    .flush_i       (flush),
    .ex_valid_o    (ex_valid),
    .ex_ready_i    (ex_ready),
    .ex_pc_o       (ex_pc),
    .ex_insn_o     (ex_insn),
    .ex_rs1data_o  (ex_rs1data),
    .ex_rs2data_o  (ex_rs2data),
    .ex_rd_o       (ex_rd),
    .ex_regwren_o  (ex_regwren),
    .ex_memren_o   (ex_memren),
    .ex_fwd_rs1_o  (ex_fwd_rs1),
    .ex_fwd_rs2_o  (ex_fwd_rs2),
    .stall_cnt_o   (stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] insn,
                       input logic u1, input logic u2, input logic wr, input logic ld,
                       input logic [31:0] d1, input logic [31:0] d2);
    id_valid    = 1'b1;
    id_pc       = pc;
    id_insn     = insn;
    id_rs1      = insn[19:15];
    id_rs2      = insn[24:20];
    id_rd       = insn[11:7];
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_regwren  = wr;
    id_memren   = ld;
    rs1data     = d1;
    rs2data     = d2;
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0;
    id_regwren  = 1'b0;
    id_memren   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"},   ex_valid,   0);
    chk({tag, "_regwren"}, ex_regwren, 0);
    chk({tag, "_memren"},  ex_memren,  0);
    chk({tag, "_fwd1"},    ex_fwd_rs1, 0);
    chk({tag, "_fwd2"},    ex_fwd_rs2, 0);
    chk({tag, "_pc"},      ex_pc,      0);
    chk({tag, "_insn"},    ex_insn,    0);
    chk({tag, "_rs1data"}, ex_rs1data, 0);
    chk({tag, "_rs2data"}, ex_rs2data, 0);
    chk({tag, "_rd"},      ex_rd,      0);
    chk({tag, "_stall"},   stall_cnt,  0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    ex_ready = 1'b0;
    mem_valid = 1'b0;
    mem_regwren = 1'b0;
    mem_rd = 5'd0;
    mem_data = 32'd0;
    id_pc = 32'd0;
    id_insn = 32'd0;
    id_rs1 = 5'd0;
    id_rs2 = 5'd0;
    id_rd = 5'd0;
    rs1data = 32'd0;
    rs2data = 32'd0;
    idle();
    tick();
    tick();
    chk_reset_state("reset");
    id_valid = 1'b1;
    #1;
    chk("reset_id_ready", id_ready, 0);

    // ALU-to-ALU: ADD x5,x1,x2 then ADD x6,x5,x1 flags rs1 forward.
    rst = 1'b0;
    ex_ready = 1'b1;
    drive(32'h100, 32'h002082B3, 1, 1, 1, 0, 32'h11, 32'h22);
    #1;
    chk("add1_id_ready", id_ready, 1);
    tick();
    chk("add1_valid", ex_valid, 1);
    chk("add1_pc", ex_pc, 32'h100);
    chk("add1_insn", ex_insn, 32'h002082B3);
    chk("add1_rs1data", ex_rs1data, 32'h11);
    chk("add1_rs2data", ex_rs2data, 32'h22);
    chk("add1_rd", ex_rd, 5);
    chk("add1_regwren", ex_regwren, 1);
    chk("add1_fwd1", ex_fwd_rs1, 0);
    drive(32'h104, 32'h00128333, 1, 1, 1, 0, 32'h55, 32'h11);
    tick();
    chk("add2_valid", ex_valid, 1);
    chk("add2_rd", ex_rd, 6);
    chk("add2_fwd1", ex_fwd_rs1, 1);
    chk("add2_fwd2", ex_fwd_rs2, 0);

    // Load-use: LW x5 then ADD x6,x5,x0 -> one bubble, then MEM bypass.
    drive(32'h108, 32'h0000A283, 1, 0, 1, 1, 32'h0, 32'h0);
    tick();
    chk("lw_memren", ex_memren, 1);
    chk("lw_fwd1", ex_fwd_rs1, 0);
    drive(32'h10C, 32'h00028333, 1, 1, 1, 0, 32'h99, 32'h77);
    #1;
    chk("lu_id_ready", id_ready, 0);
    chk("lu_stall_before", stall_cnt, 0);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_regwren", ex_regwren, 0);
    chk("lu_bubble_memren", ex_memren, 0);
    chk("lu_stall_after", stall_cnt, 1);
    mem_valid = 1'b1;
    mem_regwren = 1'b1;
    mem_rd = 5'd5;
    mem_data = 32'hDEAD_BEEF;
    #1;
    chk("lu_id_ready_release", id_ready, 1);
    tick();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_pc", ex_pc, 32'h10C);
    chk("lu_add_rs1data", ex_rs1data, 32'hDEAD_BEEF);
    chk("lu_add_rs2data_x0", ex_rs2data, 0);
    chk("lu_add_fwd1", ex_fwd_rs1, 0);
    chk("lu_add_stall", stall_cnt, 1);
    mem_valid = 1'b0;
    mem_regwren = 1'b0;

    // Backpressure: output held for three cycles.
    ex_ready = 1'b0;
    drive(32'h110, 32'h002083B3, 1, 1, 1, 0, 32'h1, 32'h2);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_id_ready", id_ready, 0);
      tick();
      chk("bp_valid", ex_valid, 1);
      chk("bp_pc", ex_pc, 32'h10C);
      chk("bp_rs1data", ex_rs1data, 32'hDEAD_BEEF);
      chk("bp_rd", ex_rd, 6);
      chk("bp_stall", stall_cnt, 1);
    end
    ex_ready = 1'b1;
    tick();
    chk("bp_release_pc", ex_pc, 32'h110);
    chk("bp_release_rs1data", ex_rs1data, 32'h1);
    chk("bp_release_fwd1", ex_fwd_rs1, 0);

    // Flush during a load-use stall.
    drive(32'h114, 32'h00012403, 1, 0, 1, 1, 32'h0, 32'h0);
    tick();
    chk("fl_lw_rd", ex_rd, 8);
    drive(32'h118, 32'h001404B3, 1, 1, 1, 0, 32'h3, 32'h4);
    #1;
    chk("fl_stall_id_ready", id_ready, 0);
    flush = 1'b1;
    #1;
    chk("fl_id_ready", id_ready, 1);
    tick();
    chk("fl_valid", ex_valid, 0);
    chk("fl_regwren", ex_regwren, 0);
    chk("fl_stall", stall_cnt, 1);
    flush = 1'b0;
    idle();
    tick();
    chk("fl_dropped_valid", ex_valid, 0);
    chk("fl_dropped_stall", stall_cnt, 1);

    // x0 source ignores a MEM result that targets x0.
    mem_valid = 1'b1;
    mem_regwren = 1'b1;
    mem_rd = 5'd0;
    mem_data = 32'h1234;
    drive(32'h11C, 32'h00100533, 1, 1, 1, 0, 32'h5555, 32'h20);
    tick();
    chk("x0_rs1data", ex_rs1data, 0);
    chk("x0_rs2data", ex_rs2data, 32'h20);
    chk("x0_fwd1", ex_fwd_rs1, 0);
    mem_valid = 1'b0;
    mem_regwren = 1'b0;

    // ADDI x11,x10,10: rs2 field names x10 but is unused -> no rs2 forward.
    drive(32'h120, 32'h00A50593, 1, 0, 1, 0, 32'h0, 32'h0);
    tick();
    chk("unused_fwd1", ex_fwd_rs1, 1);
    chk("unused_fwd2", ex_fwd_rs2, 0);

    // Saturation of the stall counter.
    drive(32'h124, 32'h00002603, 1, 0, 1, 1, 32'h0, 32'h0);
    tick();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    drive(32'h128, 32'h000606B3, 1, 1, 1, 0, 32'hA, 32'hB);
    tick();
    chk("sat_bubble_valid", ex_valid, 0);
    chk("sat_stall", stall_cnt, 32'hFFFF_FFFF);
    tick();
    chk("sat_add_valid", ex_valid, 1);
    chk("sat_add_pc", ex_pc, 32'h128);

    // Reset in the middle of a load-use stall.
    drive(32'h12C, 32'h00002703, 1, 0, 1, 1, 32'h0, 32'h0);
    tick();
    chk("rst_lw_memren", ex_memren, 1);
    drive(32'h130, 32'h000707B3, 1, 1, 1, 0, 32'hC, 32'hD);
    #1;
    chk("rst_stall_id_ready", id_ready, 0);
    rst = 1'b1;
    #1;
    chk("rst_id_ready", id_ready, 0);
    tick();
    chk_reset_state("rst2");
    rst = 1'b0;
    idle();
    tick();
    chk("rst_dropped_valid", ex_valid, 0);
    chk("rst_dropped_stall", stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL take parameter DWIDTH, default 32, as the operand/data width.
REQ-002 The block SHALL take parameter AWIDTH, default 32, as the PC width.
REQ-003 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-004 id_valid_i  in  1  decode holds a valid instruction; id_ready_o  out  1  this stage accepts it this cycle.
REQ-005 id_pc_i  in  AWIDTH; id_insn_i  in  32; id_rs1_i, id_rs2_i, id_rd_i  in  5 each  decoded fields.
REQ-006 id_uses_rs1_i, id_uses_rs2_i, id_regwren_i, id_memren_i (load)  in  1 each  decoded control.
REQ-007 rs1data_i, rs2data_i  in  DWIDTH  register-file read data, already WB write-through bypassed.
REQ-008 mem_valid_i, mem_regwren_i  in  1; mem_rd_i  in  5; mem_data_i  in  DWIDTH  final MEM-stage result, load data included.
REQ-009 flush_i  in  1  branch/jump redirect; kills wrong-path work.
REQ-010 ex_valid_o  out  1; ex_ready_i  in  1  execute accepts the output register.
REQ-011 ex_pc_o, ex_insn_o, ex_rs1data_o, ex_rs2data_o, ex_rd_o, ex_regwren_o, ex_memren_o  out  registered copies.
REQ-012 ex_fwd_rs1_o, ex_fwd_rs2_o  out  1  execute must substitute its own previous ALU result for that operand.
REQ-013 stall_cnt_o  out  32  count of load-use bubble cycles.

Function
REQ-014 Transfer in: id_valid_i && id_ready_o; transfer out: ex_valid_o && ex_ready_i.
REQ-015 Output register SHALL be free when !ex_valid_o or ex_ready_i.
REQ-016 Load-use hazard SHALL be ex_valid_o && ex_memren_o && ex_rd_o!=0 && ((id_uses_rs1_i && id_rs1_i==ex_rd_o) || (id_uses_rs2_i && id_rs2_i==ex_rd_o)).
REQ-017 id_ready_o SHALL equal flush_i || (free && !hazard), combinationally.
REQ-018 On free && hazard && !flush_i: next ex_valid_o=0 (bubble), stall_cnt_o increments, ID instruction held.
REQ-019 On transfer in without flush: all ex_* fields load, ex_valid_o=1 next cycle; latency exactly 1 cycle.
REQ-020 Operand capture priority per source: src==0 -> 0; mem_valid_i && mem_regwren_i && mem_rd_i==src -> mem_data_i; else rsXdata_i.
REQ-021 ex_fwd_rsX_o SHALL be set at capture iff the current output register is valid, non-load, ex_regwren_o, ex_rd_o!=0, and ex_rd_o equals used source X; the fwd flag overrides the captured data.
REQ-022 When !free, every ex_* output SHALL hold its value unchanged.
REQ-023 flush_i SHALL clear ex_valid_o next cycle regardless of ex_ready_i, discard the ID instruction, and not count a stall; it has priority over hazard and capture.
REQ-024 Unused sources (id_uses_rsX_i=0) SHALL never cause a hazard or forward.
REQ-025 stall_cnt_o SHALL saturate at 32'hFFFF_FFFF.
REQ-026 Bubble outputs: ex_regwren_o=0, ex_memren_o=0, fwd flags=0, so no downstream side effects.

Reset
REQ-027 On rst: ex_valid_o=0, ex_regwren_o=0, ex_memren_o=0, fwd flags=0, ex_pc_o/insn/data/rd=0, stall_cnt_o=0.
REQ-028 id_ready_o SHALL be 0 while rst is high; rst mid-stall SHALL drop the held instruction.

Structure
REQ-029 The shared package SHALL hold the id_ex_t struct (pc, insn, rd, data, control bits), the ZERO_REG constant and the x0-compare helper.
REQ-030 The block SHALL instantiate one sub-module, operand_fwd_mux, holding REQ-020/021 selection per source; hazard and register logic stay at top.

Verification
REQ-031 ADD x5 accepted, then ADD x6,x5,x1 with ex_ready_i=1 -> second capture has ex_fwd_rs1_o=1, ex_fwd_rs2_o=0.
REQ-032 LW x5, then ADD x6,x5,x0 -> one bubble (ex_valid_o=0 one cycle), stall_cnt_o 0->1; then ADD captured with mem_data_i=0xDEAD_BEEF as rs1.
REQ-033 ex_ready_i=0 for 3 cycles with valid output -> id_ready_o=0, ex_* constant, stall_cnt_o unchanged.
REQ-034 flush_i during load-use stall -> ex_valid_o=0 next cycle, ID instruction dropped, stall_cnt_o unchanged.
REQ-035 rs1=x0 with mem_rd_i=0, mem_regwren_i=1, mem_data_i=0x1234 -> ex_rs1data_o=0, no fwd flag.
REQ-036 Force stall_cnt_o to 0xFFFF_FFFF, trigger load-use -> value stays 0xFFFF_FFFF; assert rst -> all REQ-027 values next cycle.
